// File: rtl/clk_mon_pkg.sv
// Shared types for the slow-clock period monitor: FSM state encoding and
// the error-counter ceiling.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } mon_state_e;

  localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level plus an edge flop; emits
// registered, mutually exclusive one-cycle rise/fall strobes.
module sync_edge_det (
  input  logic I_CLK,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;
  logic rise_q, fall_q;

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Samples S_CLK in the I_CLK domain, measures each half-period in I_CLK
// cycles and tracks lock / loss-of-clock with a saturating error count.
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_HALF = 4,
  parameter int TOL      = 0,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1024,
  parameter int LOCK_N   = 4
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             S_CLK,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic [7:0]       err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      LO      = 32'((EXP_HALF > TOL) ? EXP_HALF - TOL : 0);
  localparam logic [31:0]      HI      = 32'(EXP_HALF + TOL);
  localparam int               GC_W    = $clog2(LOCK_N + 1);

  logic             rise_s, fall_s, edge_s;
  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] meas;
  logic [GC_W-1:0]  gc_q, gc_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic             pv_q, pv_d;
  logic [7:0]       err_q, err_d;
  logic             locked_q, lost_q;
  logic             good, timeout;

  sync_edge_det u_sync (
    .I_CLK  (I_CLK),
    .rst    (rst),
    .d_i    (S_CLK),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  assign edge_s  = rise_s | fall_s;
  assign meas    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
  assign good    = (32'(meas) >= LO) && (32'(meas) <= HI);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gc_d    = gc_q;
    hp_d    = hp_q;
    pv_d    = 1'b0;
    err_d   = err_q;

    // Counting is frozen while LOST; the next edge restarts it from zero.
    if (edge_s)
      cnt_d = '0;
    else if (state_q != ST_LOST && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);

    if (edge_s) begin
      case (state_q)
        ST_IDLE, ST_LOST: begin
          state_d = ST_ACQUIRE;
          gc_d    = '0;
        end
        ST_ACQUIRE: begin
          hp_d = meas;
          pv_d = 1'b1;
          if (good) begin
            gc_d = gc_q + GC_W'(1);
            if (gc_d == GC_W'(LOCK_N)) state_d = ST_LOCKED;
          end else begin
            gc_d = '0;
          end
        end
        ST_LOCKED: begin
          hp_d = meas;
          pv_d = 1'b1;
          if (!good) begin
            if (err_q != ERR_MAX) err_d = err_q + 8'd1;
            gc_d    = '0;
            state_d = ST_ACQUIRE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_LOST && timeout) begin
      state_d = ST_LOST;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gc_q     <= '0;
      hp_q     <= '0;
      pv_q     <= 1'b0;
      err_q    <= 8'd0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gc_q     <= gc_d;
      hp_q     <= hp_d;
      pv_q     <= pv_d;
      err_q    <= err_d;
      locked_q <= (state_d == ST_LOCKED);
      lost_q   <= (state_d == ST_LOST);
    end
  end

  assign rise_pulse   = rise_s;
  assign fall_pulse   = fall_s;
  assign half_period  = hp_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign lost         = lost_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Randomised bench for clk_period_monitor: an edge-time model predicts every
// output each cycle; literal checks pin the key scenarios.
module tb_clk_period_monitor;

  localparam int EXP_HALF = 4;
  localparam int TOL      = 0;
  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 1024;
  localparam int LOCK_N   = 4;
  localparam int HMASK    = 32'h7FFF;

  logic             I_CLK = 1'b0;
  logic             rst   = 1'b0;
  logic             S_CLK = 1'b0;
  logic             rise_pulse, fall_pulse, period_valid, locked, lost;
  logic [CNT_W-1:0] half_period;
  logic [7:0]       err_cnt;

  int errors = 0;
  int checks = 0;

  clk_period_monitor #(
    .EXP_HALF (EXP_HALF), .TOL (TOL), .CNT_W (CNT_W),
    .TIMEOUT  (TIMEOUT),  .LOCK_N (LOCK_N)
  ) dut (
    .I_CLK        (I_CLK),
    .rst          (rst),
    .S_CLK        (S_CLK),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost),
    .err_cnt      (err_cnt)
  );

  always #5 I_CLK = ~I_CLK;

  // Model: a sampled S_CLK change shows up as a strobe two posedges later;
  // a half-period is the distance in cycles between consecutive strobes.
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_LOST = 3;
  bit vh [0:HMASK];
  int cyc = 0;
  int anchor = 0;
  int mst = M_IDLE;
  int mgc = 0;
  int merr = 0;
  int mhp = 0;
  bit mpv = 0, mrise = 0, mfall = 0, minit = 0;

  always @(posedge I_CLK) begin
    int p, c, m;
    cyc++;
    p = cyc;
    if (rst) begin
      vh[p & HMASK] = 0; vh[(p-1) & HMASK] = 0; vh[(p-2) & HMASK] = 0;
      mst = M_IDLE; mgc = 0; merr = 0; mhp = 0; mpv = 0;
      mrise = 0; mfall = 0; anchor = p - 1; minit = 1;
    end else begin
      vh[p & HMASK] = S_CLK;
      c   = p - 1;
      mpv = 0;
      if (mrise || mfall) begin
        m = c - anchor;
        if (m > 65535) m = 65535;
        anchor = c;
        if (mst == M_IDLE || mst == M_LOST) begin
          mst = M_ACQ; mgc = 0;
        end else begin
          mpv = 1; mhp = m;
          if (m >= EXP_HALF - TOL && m <= EXP_HALF + TOL) begin
            if (mst == M_ACQ) begin
              mgc++;
              if (mgc == LOCK_N) mst = M_LOCK;
            end
          end else begin
            if (mst == M_LOCK && merr < 255) merr++;
            mgc = 0;
            mst = M_ACQ;
          end
        end
      end else if (mst != M_LOST && (c - anchor) == TIMEOUT) begin
        mst = M_LOST;
      end
      mrise = vh[(p-2) & HMASK] & ~vh[(p-3) & HMASK];
      mfall = ~vh[(p-2) & HMASK] & vh[(p-3) & HMASK];
    end
  end

  always @(negedge I_CLK) begin
    if (minit) begin
      checks++;
      if (rise_pulse !== mrise || fall_pulse !== mfall || period_valid !== mpv ||
          half_period !== 16'(mhp) || locked !== (mst == M_LOCK) ||
          lost !== (mst == M_LOST) || err_cnt !== 8'(merr)) begin
        errors++;
        $display("FAIL model cyc=%0d got r=%b f=%b pv=%b hp=%0d lk=%b lo=%b err=%0d exp r=%b f=%b pv=%b hp=%0d lk=%b lo=%b err=%0d",
                 cyc, rise_pulse, fall_pulse, period_valid, half_period, locked, lost, err_cnt,
                 mrise, mfall, mpv, mhp, mst == M_LOCK, mst == M_LOST, merr);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge I_CLK);
    #1;
  endtask

  task automatic half(input int n);
    wait_cyc(n);
    S_CLK = ~S_CLK;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_rise"}, int'(rise_pulse), 0);
    chk({name, "_fall"}, int'(fall_pulse), 0);
    chk({name, "_pv"},   int'(period_valid), 0);
    chk({name, "_hp"},   int'(half_period), 0);
    chk({name, "_lock"}, int'(locked), 0);
    chk({name, "_lost"}, int'(lost), 0);
    chk({name, "_err"},  int'(err_cnt), 0);
  endtask

  initial begin
    int t;
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1; S_CLK = 0;
    wait_cyc(3);
    chk_zero("reset");
    rst = 0;

    // Strobe latency and initial lock at EXP_HALF.
    wait_cyc(2);
    S_CLK = 1; t = cyc;
    wait_cyc(2); chk("rise_t2", int'(rise_pulse), 0);
    wait_cyc(1); chk("rise_t3", int'(rise_pulse), 1); chk("fall_t3", int'(fall_pulse), 0);
    wait_cyc(1); chk("rise_t4", int'(rise_pulse), 0);
    S_CLK = 0;
    repeat (5) half(4);
    chk("lock1", int'(locked), 1);
    chk("hp4", int'(half_period), 4);
    chk("err0", int'(err_cnt), 0);

    // One long half-period while locked.
    half(6);
    wait_cyc(4);
    chk("bad_hp", int'(half_period), 6);
    chk("bad_pv", int'(period_valid), 1);
    chk("bad_err", int'(err_cnt), 1);
    chk("bad_unlock", int'(locked), 0);
    S_CLK = ~S_CLK;
    repeat (4) half(4);
    chk("relock", int'(locked), 1);

    // Loss of clock and recovery.
    wait_cyc(1100);
    chk("lost1", int'(lost), 1);
    chk("lost_lock", int'(locked), 0);
    S_CLK = ~S_CLK;
    wait_cyc(5);
    chk("lost_exit", int'(lost), 0);
    repeat (6) half(4);
    chk("lost_relock", int'(locked), 1);

    // Random half-periods, biased toward the expected value.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) half(EXP_HALF);
      else half($urandom_range(1, 9));
    end
    wait_cyc(TIMEOUT + 10);
    for (int i = 0; i < 60; i++) half($urandom_range(3, 5));

    // Reset in ACQUIRE with three good measurements banked.
    rst = 1; wait_cyc(2); rst = 0;
    repeat (4) half(4);
    wait_cyc(5);
    rst = 1;
    wait_cyc(1);
    chk_zero("midrst");
    rst = 0;

    // Lock / fail loop until the error counter saturates.
    for (int i = 0; i < 300; i++) begin
      repeat (4) half(4);
      half(6);
    end
    wait_cyc(6);
    chk("err_sat", int'(err_cnt), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
